// File: rtl/div_unit.sv
// Iterative restoring divider: one quotient bit per cycle, 64-bit or word mode, signed/unsigned.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iterations and completes on the accept edge.
module div_unit #(
   parameter int unsigned XLEN = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              div_valid,
   input  logic              div_32,
   input  logic              div_signed,
   input  logic [XLEN-1:0]   dividend,
   input  logic [XLEN-1:0]   divisor,
   input  logic              div_ack,
   input  logic              flush,
   output logic              div_ready,
   output logic [2*XLEN-1:0] div_result,
   output logic              div_busy
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e              state_q, state_d;
   logic [XLEN-1:0]     rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [6:0]          cnt_q, cnt_d;
   logic                qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d, w32_q, w32_d;
   logic [2*XLEN-1:0]   result_q, result_d;

   logic [XLEN-1:0]     a_ext, b_ext, a_abs, b_abs, a_word;
   logic                a_neg, b_neg, b_zero;
   logic [XLEN:0]       rem_sh, rem_sub;
   logic                ge;
   logic [XLEN-1:0]     rem_it, quo_it, q_fix, r_fix, q_out, r_out;

   always_comb begin
      // Word mode works on bits [31:0], extended to full width before the abs step
      if (div_32) begin
         a_ext = div_signed ? {{(XLEN-32){dividend[31]}}, dividend[31:0]}
                            : {{(XLEN-32){1'b0}}, dividend[31:0]};
         b_ext = div_signed ? {{(XLEN-32){divisor[31]}}, divisor[31:0]}
                            : {{(XLEN-32){1'b0}}, divisor[31:0]};
      end else begin
         a_ext = dividend;
         b_ext = divisor;
      end
      a_neg  = div_signed & a_ext[XLEN-1];
      b_neg  = div_signed & b_ext[XLEN-1];
      a_abs  = a_neg ? -a_ext : a_ext;
      b_abs  = b_neg ? -b_ext : b_ext;
      b_zero = (b_ext == '0);
      a_word = div_32 ? {{(XLEN-32){dividend[31]}}, dividend[31:0]} : dividend;

      // One restoring step; the remainder needs an extra bit before the compare
      rem_sh  = {rem_q, quo_q[XLEN-1]};
      rem_sub = rem_sh - {1'b0, dvs_q};
      ge      = (rem_sh >= {1'b0, dvs_q});
      rem_it  = ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
      quo_it  = {quo_q[XLEN-2:0], ge};

      // Divide by zero keeps the all-ones quotient unnegated
      q_fix = (qneg_q && !zero_q) ? -quo_it : quo_it;
      r_fix = rneg_q ? -rem_it : rem_it;
      q_out = w32_q ? {{(XLEN-32){q_fix[31]}}, q_fix[31:0]} : q_fix;
      r_out = w32_q ? {{(XLEN-32){r_fix[31]}}, r_fix[31:0]} : r_fix;
   end

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      cnt_d    = cnt_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      zero_d   = zero_q;
      w32_d    = w32_q;
      result_d = result_q;

      unique case (state_q)
         StIdle: begin
            if (!flush && div_valid) begin
               rem_d  = '0;
               quo_d  = div_32 ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
               dvs_d  = b_abs;
               cnt_d  = div_32 ? 7'd32 : 7'd64;
               qneg_d = a_neg ^ b_neg;
               rneg_d = a_neg;
               zero_d = b_zero;
               w32_d  = div_32;
`ifdef DIV_ZERO_FAST_EN
               if (b_zero) begin
                  state_d  = StDone;
                  result_d = {a_word, {XLEN{1'b1}}};
               end else begin
                  state_d = StBusy;
               end
`else
               state_d = StBusy;
`endif
            end
         end
         StBusy: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               rem_d = rem_it;
               quo_d = quo_it;
               cnt_d = cnt_q - 7'd1;
               // Last iteration: register the corrected result on this same edge
               if (cnt_q == 7'd1) begin
                  state_d  = StDone;
                  result_d = {r_out, q_out};
               end
            end
         end
         StDone: begin
            if (flush || div_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         zero_q   <= 1'b0;
         w32_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         cnt_q    <= cnt_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         zero_q   <= zero_d;
         w32_q    <= w32_d;
         result_q <= result_d;
      end
   end

   assign div_ready  = (state_q == StDone);
   assign div_busy   = (state_q == StBusy);
   assign div_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, randomized ops against an arithmetic model,
// flush, delayed ack with back-to-back request, and mid-operation reset.
module tb_div_unit;

   logic         clk = 1'b0;
   logic         rst;
   logic         div_valid, div_32, div_signed, div_ack, flush;
   logic [63:0]  dividend, divisor;
   logic         div_ready, div_busy;
   logic [127:0] div_result;

   int errors = 0;
   int checks = 0;

   div_unit #(.XLEN(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .div_valid  (div_valid),
      .div_32     (div_32),
      .div_signed (div_signed),
      .dividend   (dividend),
      .divisor    (divisor),
      .div_ack    (div_ack),
      .flush      (flush),
      .div_ready  (div_ready),
      .div_result (div_result),
      .div_busy   (div_busy)
   );

   always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
   localparam bit FastZero = 1'b1;
`else
   localparam bit FastZero = 1'b0;
`endif

   // Reference model: {remainder, quotient}; word mode fills only the low 32 bits of each half
   function automatic logic [127:0] model(input logic w, input logic s,
                                          input logic [63:0] a, input logic [63:0] b);
      logic [31:0] a32, b32, q32, r32;
      logic [63:0] q, r;
      if (w) begin
         a32 = a[31:0];
         b32 = b[31:0];
         if (b32 == 32'd0) begin
            q32 = 32'hFFFF_FFFF; r32 = a32;
         end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
            q32 = a32; r32 = 32'd0;
         end else if (s) begin
            q32 = $signed(a32) / $signed(b32);
            r32 = $signed(a32) % $signed(b32);
         end else begin
            q32 = a32 / b32;
            r32 = a32 % b32;
         end
         q = {32'd0, q32};
         r = {32'd0, r32};
      end else begin
         if (b == 64'd0) begin
            q = '1; r = a;
         end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a; r = 64'd0;
         end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end else begin
            q = a / b;
            r = a % b;
         end
      end
      return {r, q};
   endfunction

   function automatic logic [127:0] res_mask(input logic w);
      return w ? {32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF} : '1;
   endfunction

   function automatic int exp_lat(input logic w, input logic [63:0] b);
      logic zero;
      zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
      if (FastZero && zero) return 1;
      return w ? 33 : 65;
   endfunction

   // Drive a request; returns just after the accept edge with operands scrambled
   task automatic start(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b);
      div_32 = w; div_signed = s; dividend = a; divisor = b; div_valid = 1'b1;
      @(posedge clk); #1;
      div_valid = 1'b0;
      dividend = {$urandom, $urandom};
      divisor  = {$urandom, $urandom};
      div_32 = $urandom_range(0, 1);
      div_signed = $urandom_range(0, 1);
   endtask

   task automatic wait_done(output int n);
      n = 1;
      while (!div_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic ack_once();
      div_ack = 1'b1;
      @(posedge clk); #1;
      div_ack = 1'b0;
   endtask

   task automatic run_check(input string name, input logic w, input logic s,
                            input logic [63:0] a, input logic [63:0] b);
      int n;
      logic [127:0] exp, msk;
      exp = model(w, s, a, b);
      msk = res_mask(w);
      start(w, s, a, b);
      wait_done(n);
      checks++;
      if (n !== exp_lat(w, b)) begin
         errors++;
         $display("FAIL %s latency: got %0d expected %0d", name, n, exp_lat(w, b));
      end
      checks++;
      if ((div_result & msk) !== (exp & msk)) begin
         errors++;
         $display("FAIL %s result: got %h expected %h", name, div_result & msk, exp & msk);
      end
      ack_once();
      checks++;
      if (div_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s ready after ack: got %b expected 0", name, div_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      div_valid = 0; div_32 = 0; div_signed = 0; div_ack = 0; flush = 0;
      dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (div_ready !== 1'b0 || div_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset flags: got ready=%b busy=%b expected 0 0", div_ready, div_busy);
      end
      checks++;
      if (div_result !== 128'd0) begin
         errors++;
         $display("FAIL reset result: got %h expected 0", div_result);
      end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      run_check("u64_100_7", 1'b0, 1'b0, 64'd100, 64'd7);
      checks++;
      if (model(1'b0, 1'b0, 64'd100, 64'd7) !== {64'd2, 64'd14}) begin
         errors++;
         $display("FAIL model_100_7: got %h expected %h",
                  model(1'b0, 1'b0, 64'd100, 64'd7), {64'd2, 64'd14});
      end
      run_check("w_neg7_2", 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
      run_check("s64_ovf", 1'b0, 1'b1, 64'h8000_0000_0000_0000, '1);
      run_check("w_ovf", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
      run_check("s64_5_0", 1'b0, 1'b1, 64'd5, 64'd0);
      run_check("w_neg5_0", 1'b1, 1'b1, 64'h1234_5678_FFFF_FFFB, 64'hABCD_0000_0000_0000);
      // Busy must be visible right after a normal accept
      start(1'b0, 1'b0, 64'd1000, 64'd3);
      checks++;
      if (div_busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_accept: got %b expected 1", div_busy);
      end
      begin
         int n;
         wait_done(n);
      end
      ack_once();
   endtask

   task automatic test_random();
      logic [63:0] a, b;
      logic w, s;
      for (int i = 0; i < 40; i++) begin
         a = {$urandom, $urandom};
         w = $urandom_range(0, 1);
         s = $urandom_range(0, 1);
         case ($urandom_range(0, 4))
            0: b = '0;
            1: b = 64'($urandom_range(1, 20));
            2: b = -64'($urandom_range(1, 20));
            3: b = {32'd0, $urandom};
            default: b = {$urandom, $urandom};
         endcase
         if ($urandom_range(0, 7) == 0) begin
            a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
            b = '1;
         end
         run_check("random", w, s, a, b);
      end
   endtask

   task automatic test_flush();
      int seen;
      div_32 = 0; div_signed = 0; dividend = 64'd100; divisor = 64'd7; div_valid = 1'b1;
      @(posedge clk); #1;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      div_valid = 1'b0;
      checks++;
      if (div_busy !== 1'b0 || div_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle: got busy=%b ready=%b expected 0 0", div_busy, div_ready);
      end
      seen = 0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk); #1;
         if (div_ready) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL flush_no_ready: got %0d ready cycles expected 0", seen);
      end
      run_check("after_flush", 1'b0, 1'b1, -64'd1000, 64'd9);
   endtask

   task automatic test_back_to_back();
      int n;
      logic [127:0] held, exp2;
      int unstable;
      start(1'b0, 1'b0, 64'd12345, 64'd11);
      wait_done(n);
      held = div_result;
      checks++;
      if (held !== model(1'b0, 1'b0, 64'd12345, 64'd11)) begin
         errors++;
         $display("FAIL b2b_first: got %h expected %h", held, model(1'b0, 1'b0, 64'd12345, 64'd11));
      end
      unstable = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (div_result !== held || div_ready !== 1'b1) unstable++;
      end
      checks++;
      if (unstable !== 0) begin
         errors++;
         $display("FAIL done_hold: got %0d unstable cycles expected 0", unstable);
      end
      // Request presented in the ack cycle must wait one more cycle
      exp2 = model(1'b0, 1'b1, -64'd77, 64'd5);
      div_32 = 0; div_signed = 1; dividend = -64'd77; divisor = 64'd5;
      div_valid = 1'b1; div_ack = 1'b1;
      @(posedge clk); #1;
      div_ack = 1'b0;
      checks++;
      if (div_ready !== 1'b0 || div_busy !== 1'b0) begin
         errors++;
         $display("FAIL ack_cycle_no_accept: got ready=%b busy=%b expected 0 0",
                  div_ready, div_busy);
      end
      @(posedge clk); #1;
      div_valid = 1'b0;
      checks++;
      if (div_busy !== 1'b1) begin
         errors++;
         $display("FAIL accept_next_cycle: got busy=%b expected 1", div_busy);
      end
      wait_done(n);
      checks++;
      if (n !== 65 || div_result !== exp2) begin
         errors++;
         $display("FAIL b2b_second: got lat=%0d res=%h expected lat=65 res=%h",
                  n, div_result, exp2);
      end
      ack_once();
   endtask

   task automatic test_reset_mid();
      int seen;
      start(1'b0, 1'b0, 64'd999, 64'd4);
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (div_ready !== 1'b0 || div_busy !== 1'b0 || div_result !== 128'd0) begin
         errors++;
         $display("FAIL reset_mid: got ready=%b busy=%b res=%h expected 0 0 0",
                  div_ready, div_busy, div_result);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (div_ready || div_busy) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL reset_no_pulse: got %0d active cycles expected 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      run_check("post_reset", 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd16);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
